seq_chunk_adder: RTL and testbench
==================================

// Module: seq_chunk_adder
// PURPOSE
//  Parametrised multi-cycle unsigned adder/subtractor: A_W-bit A op zero-extended B_W-bit B.
//  Processes CHUNK_W bits per cycle through one ripple chunk, so wide mantissa/product adds
//  can close timing in the datapath. Replaces the fixed 56/15 zero-extend adders.
//  Valid/ready on both input and output sides.
// PARAMETERS
//  A_W      56  width of operand A and of the result body (>=2)
//  B_W      15  width of operand B, zero-extended to A_W (1 <= B_W <= A_W)
//  CHUNK_W   8  bits added per cycle (1 <= CHUNK_W <= A_W)
//  N_CHUNKS     derived localparam: ceil(A_W/CHUNK_W); operands are zero-padded to N_CHUNKS*CHUNK_W internally
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       operands present
//  in_ready   out  1       block can accept operands this cycle
//  in_a       in   A_W     operand A
//  in_b       in   B_W     operand B (zero-extended)
//  in_sub     in   1       0: A+B, 1: A-B
//  out_valid  out  1       result present
//  out_ready  in   1       consumer accepts result
//  out_sum    out  A_W+1   [A_W-1:0] result mod 2^A_W; [A_W] carry (add) or borrow (sub)
//  busy       out  1       high in RUN
// BEHAVIOUR
//  - States: IDLE, RUN, DONE. Reset forces IDLE, chunk_idx=0, out_sum=0, carry=0.
//  - Outputs during and on reset: out_valid=0, busy=0, in_ready=0 while rst=1.
//  - in_ready = ~rst & (IDLE | (DONE & out_ready)). Acceptance = in_valid & in_ready.
//  - Acceptance: register A, B_ext = {0,in_b} (bitwise-inverted if in_sub), carry=in_sub, sub flag, chunk_idx=0 -> RUN.
//  - RUN: each cycle, chunk chunk_idx = A_chunk + B_chunk + carry. Write into result reg; forward carry.
//    At chunk_idx == N_CHUNKS-1 -> DONE; else chunk_idx++.
//  - Latency: out_valid rises N_CHUNKS cycles after the accepting edge. Throughput: one op per N_CHUNKS+1 cycles.
//  - Carry/borrow: out_sum[A_W] = carry out of bit A_W-1 (add), or ~carry (sub; 1 when A<B).
//    With padding, carry is taken at bit A_W-1, not from the padded top chunk.
//  - DONE: out_valid=1; out_sum stable until out_ready.
//    out_ready & ~in_valid -> IDLE.
//    out_ready & in_valid -> accept new operands same edge -> RUN (back-to-back).
//  - Operands sampled only at acceptance; in_a/in_b/in_sub changes at other times have no effect.
//  - rst at any state (incl. mid-RUN): operation discarded, no out_valid ever produced for it.
//  - No X on outputs after the first reset cycle.
// STRUCTURE
//  - Shared package (armflow_arith_pkg): state encoding constants, ceil_div function.
//  - One sub-module: unsigned_chunk_adder #(W) : a[W], b[W], cin -> sum[W], cout (combinational ripple).
//  - Top holds the FSM, operand/result shift-free registers indexed by chunk_idx, and the carry flop.
// TESTING
//  1 Defaults, add A=56'hFF_FFFF_FFFF_FFFF, B=15'h1 -> out_sum=57'h100_0000_0000_0000;
//    out_valid exactly 7 cycles after accept.
//  2 Defaults, sub A=0, B=15'h1 -> out_sum[55:0]=all ones, out_sum[56]=1 (borrow);
//    sub A=56'h10, B=15'h10 -> out_sum=0.
//  3 Backpressure: out_ready=0 for 5 cycles in DONE -> out_sum/out_valid held, in_ready=0;
//    then out_ready=1 -> in_ready=1 same cycle.
//  4 Back-to-back: in_valid held high, out_ready=1 -> new op accepted on DONE cycle;
//    2nd result 8 cycles after 1st; 100 random ops checked vs reference model.
//  5 Reset mid-RUN (chunk_idx=3): no out_valid; in_ready=1 on first cycle after rst falls;
//    next op (A=5, B=3, add) -> 8.
//  6 A_W=12, B_W=4, CHUNK_W=5 (N=3, padded): A=12'hFFF, B=4'hF add -> 13'h100E after 3 cycles;
//    sub A=12'h003, B=4'h4 -> 13'h1FFF.

Source files
------------

// File: rtl/armflow_arith_pkg.sv
// Shared arithmetic package: FSM state encoding and ceil_div helper.
// No ports; imported by the chunked adder files.
package armflow_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result valid-ready bundle for seq_chunk_adder.
// master: producer/consumer side; slave: the adder.
interface seq_chunk_adder_if #(
  parameter int A_W = 56,
  parameter int B_W = 15
);
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] in_a;
  logic [B_W-1:0] in_b;
  logic           in_sub;
  logic           out_valid;
  logic           out_ready;
  logic [A_W:0]   out_sum;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/seq_chunk_adder_chunk.sv
// Combinational W-bit ripple chunk: a + b + cin -> sum, cout.
// Ports: a[W], b[W], cin in; sum[W], cout out.
module unsigned_chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle A +/- zero-extended B, CHUNK_W bits per cycle.
// Ports: clk, rst (sync, high), bus (slave handshake), busy.
module seq_chunk_adder
  import armflow_arith_pkg::*;
#(
  parameter int A_W     = 56,
  parameter int B_W     = 15,
  parameter int CHUNK_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_chunk_adder_if.slave   bus,
  output logic               busy
);
  localparam int N_CHUNKS = ceil_div(A_W, CHUNK_W);
  localparam int PW = N_CHUNKS * CHUNK_W;
  localparam int IW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  // bit holding the carry out of A_W-1 once padded
  localparam int CB = (PW > A_W) ? A_W : PW - 1;
  localparam logic [IW-1:0] LAST = IW'(N_CHUNKS - 1);

  state_t state_q, state_d;
  logic [PW-1:0] a_q, b_q, res_q, res_next;
  logic [PW-1:0] a_ext, b_ext;
  logic [IW-1:0] idx_q;
  logic          carry_q, sub_q;
  logic [A_W:0]  sum_q;
  logic [CHUNK_W-1:0] ch_a, ch_b, ch_sum;
  logic          ch_cout, c_body;
  logic          accept, last;

  assign bus.in_ready = ~rst & ((state_q == IDLE)
                        | ((state_q == DONE) & bus.out_ready));
  assign bus.out_valid = ~rst & (state_q == DONE);
  assign bus.out_sum = sum_q;
  assign busy = ~rst & (state_q == RUN);

  assign accept = bus.in_valid & bus.in_ready;
  assign last = (idx_q == LAST);

  assign ch_a = a_q[int'(idx_q)*CHUNK_W +: CHUNK_W];
  assign ch_b = b_q[int'(idx_q)*CHUNK_W +: CHUNK_W];

  unsigned_chunk_adder #(.W(CHUNK_W)) u_chunk (
    .a    (ch_a),
    .b    (ch_b),
    .cin  (carry_q),
    .sum  (ch_sum),
    .cout (ch_cout)
  );

  // Padding stays zero in both operands (inversion limited to the
  // body), so the padded bit A_W of the result is the body carry.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[A_W-1:0] = bus.in_a;
    b_ext[B_W-1:0] = bus.in_b;
    if (bus.in_sub)
      b_ext[A_W-1:0] = ~b_ext[A_W-1:0];
  end

  always_comb begin
    res_next = res_q;
    res_next[int'(idx_q)*CHUNK_W +: CHUNK_W] = ch_sum;
    c_body = (PW > A_W) ? res_next[CB] : ch_cout;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: if (bus.out_ready)
              state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a_ext;
        b_q     <= b_ext;
        carry_q <= bus.in_sub;
        sub_q   <= bus.in_sub;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        res_q   <= res_next;
        carry_q <= ch_cout;
        if (last)
          sum_q <= {sub_q ? ~c_body : c_body, res_next[A_W-1:0]};
        else
          idx_q <= idx_q + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder (56/15/8 and 12/4/5).
// Directed + random ops against an arithmetic reference.
module tb_seq_chunk_adder;
  logic clk = 1'b0;
  logic rst;
  logic big_busy, sml_busy;
  int   n_assert = 0;
  int   n_fail = 0;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  seq_chunk_adder_if #(.A_W(56), .B_W(15)) big_if ();
  seq_chunk_adder_if #(.A_W(12), .B_W(4))  sml_if ();

  seq_chunk_adder #(.A_W(56), .B_W(15), .CHUNK_W(8)) dut_big (
    .clk(clk), .rst(rst), .bus(big_if), .busy(big_busy));

  seq_chunk_adder #(.A_W(12), .B_W(4), .CHUNK_W(5)) dut_sml (
    .clk(clk), .rst(rst), .bus(sml_if), .busy(sml_busy));

  function automatic logic [63:0] model(input logic [63:0] a,
      input logic [63:0] b, input bit sub, input int aw);
    logic [63:0] r;
    r = sub ? a - b : a + b;
    return r & ((64'd1 << (aw + 1)) - 64'd1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic big_op(input logic [55:0] a, input logic [14:0] b,
      input bit sub, output int lat, output logic [56:0] sum);
    big_if.in_a = a;
    big_if.in_b = b;
    big_if.in_sub = sub;
    big_if.in_valid = 1'b1;
    chk("big_in_ready", big_if.in_ready, 1);
    step;
    big_if.in_valid = 1'b0;
    chk("big_busy_run", big_busy, 1);
    lat = 0;
    while (!big_if.out_valid && lat < 40) begin
      step;
      lat++;
    end
    sum = big_if.out_sum;
  endtask

  task automatic sml_op(input logic [11:0] a, input logic [3:0] b,
      input bit sub, output int lat, output logic [12:0] sum);
    sml_if.in_a = a;
    sml_if.in_b = b;
    sml_if.in_sub = sub;
    sml_if.in_valid = 1'b1;
    step;
    sml_if.in_valid = 1'b0;
    lat = 0;
    while (!sml_if.out_valid && lat < 40) begin
      step;
      lat++;
    end
    sum = sml_if.out_sum;
  endtask

  task automatic big_drain;
    big_if.out_ready = 1'b1;
    step;
    big_if.out_ready = 1'b0;
  endtask

  task automatic sml_drain;
    sml_if.out_ready = 1'b1;
    step;
    sml_if.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt;
    logic [56:0] s57;
    logic [12:0] s13;
    logic [55:0] ra;
    logic [14:0] rb;
    logic rs;
    logic [63:0] exp;
    longint last_cyc;
    bit seen;

    big_if.in_valid = 0; big_if.in_a = '0; big_if.in_b = '0;
    big_if.in_sub = 0; big_if.out_ready = 0;
    sml_if.in_valid = 0; sml_if.in_a = '0; sml_if.in_b = '0;
    sml_if.in_sub = 0; sml_if.out_ready = 0;
    rst = 1'b1;
    step;
    step;
    chk("rst_out_valid", big_if.out_valid, 0);
    chk("rst_in_ready", big_if.in_ready, 0);
    chk("rst_busy", big_busy, 0);
    chk("rst_out_sum", big_if.out_sum, 0);
    chk("rst_sml_sum", sml_if.out_sum, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", big_if.in_ready, 1);

    // carry ripples through every chunk
    big_op(56'hFF_FFFF_FFFF_FFFF, 15'h1, 0, lat, s57);
    chk("add_lat", lat, 7);
    chk("add_sum", s57, model(56'hFF_FFFF_FFFF_FFFF, 1, 0, 56));
    chk("add_carry", s57[56], 1);
    big_drain;

    big_op(56'h0, 15'h1, 1, lat, s57);
    chk("sub_borrow_sum", s57, model(0, 1, 1, 56));
    chk("sub_borrow_bit", s57[56], 1);
    big_drain;
    big_op(56'h10, 15'h10, 1, lat, s57);
    chk("sub_zero", s57, 0);
    big_drain;

    // backpressure hold
    big_op(56'h1234_5678_9ABC_DE, 15'h7FFF, 0, lat, s57);
    exp = model(56'h1234_5678_9ABC_DE, 15'h7FFF, 0, 56);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("bp_valid", big_if.out_valid, 1);
      chk("bp_sum", big_if.out_sum, exp);
      chk("bp_in_ready", big_if.in_ready, 0);
    end
    big_if.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", big_if.in_ready, 1);
    step;
    big_if.out_ready = 1'b0;
    chk("bp_back_idle", big_if.out_valid, 0);

    // back-to-back random stream
    big_if.out_ready = 1'b1;
    ra = 56'({$urandom(), $urandom()});
    rb = 15'($urandom());
    rs = 1'($urandom());
    big_if.in_a = ra; big_if.in_b = rb; big_if.in_sub = rs;
    big_if.in_valid = 1'b1;
    exp = model(64'(ra), 64'(rb), rs, 56);
    step;
    last_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (i < 99) begin
        ra = 56'({$urandom(), $urandom()});
        rb = 15'($urandom());
        rs = 1'($urandom());
        big_if.in_a = ra; big_if.in_b = rb; big_if.in_sub = rs;
      end else begin
        big_if.in_valid = 1'b0;
      end
      cnt = 0;
      while (!big_if.out_valid && cnt < 40) begin
        step;
        cnt++;
      end
      chk("b2b_sum", big_if.out_sum, exp);
      if (i > 0) chk("b2b_gap", 64'(cyc - last_cyc), 8);
      last_cyc = cyc;
      if (i < 99) chk("b2b_in_ready", big_if.in_ready, 1);
      exp = model(64'(ra), 64'(rb), rs, 56);
      step;
    end
    big_if.out_ready = 1'b0;

    // reset mid-RUN
    big_if.in_a = 56'hABC; big_if.in_b = 15'h123; big_if.in_sub = 0;
    big_if.in_valid = 1'b1;
    step;
    big_if.in_valid = 1'b0;
    step; step; step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    #1;
    chk("midrun_ready", big_if.in_ready, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (big_if.out_valid) seen = 1;
      step;
    end
    chk("midrun_no_valid", 64'(seen), 0);
    big_op(56'd5, 15'd3, 0, lat, s57);
    chk("post_rst_lat", lat, 7);
    chk("post_rst_sum", s57, 8);
    big_drain;

    // padded small instance
    sml_op(12'hFFF, 4'hF, 0, lat, s13);
    chk("sml_lat", lat, 3);
    chk("sml_add", s13, model(12'hFFF, 4'hF, 0, 12));
    sml_drain;
    sml_op(12'h003, 4'h4, 1, lat, s13);
    chk("sml_sub", s13, model(3, 4, 1, 12));
    sml_drain;
    for (int i = 0; i < 20; i++) begin
      logic [11:0] sa;
      logic [3:0]  sb;
      logic        ss;
      sa = 12'($urandom());
      sb = 4'($urandom());
      ss = 1'($urandom());
      sml_op(sa, sb, ss, lat, s13);
      chk("sml_rand_lat", lat, 3);
      chk("sml_rand", s13, model(64'(sa), 64'(sb), ss, 12));
      sml_drain;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
